// File: rtl/shift_op_sequencer_if.sv
// rtl/shift_op_sequencer_if.sv - command, response and register-side bundle for the shift op sequencer
interface shift_op_sequencer_if #(
  parameter int W  = 10,
  parameter int CW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [W-1:0]  cmd_data;
  logic [2:0]    sel;
  logic [W-1:0]  par_out;
  logic [W-1:0]  reg_q;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, reg_q, rsp_ready,
    output cmd_ready, sel, par_out, rsp_valid, rsp_data, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, reg_q, rsp_ready,
    input  cmd_ready, sel, par_out, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/shift_op_sequencer.sv
// rtl/shift_op_sequencer.sv - turns op commands into exact sel cycle bursts for a multi-op shift register
module shift_op_sequencer #(
  parameter int W  = 10,
  parameter int CW = 4
) (
  input logic                 clk,
  input logic                 rst,
  shift_op_sequencer_if.slave bus
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_ROR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;

  logic [2:0]    sel_c;
  logic [W-1:0]  par_c;
  logic          cmd_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_HOLD;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    sel_c       = OP_HOLD;
    par_c       = '0;
    cmd_ready_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          case (bus.cmd_op)
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
              // A zero count is a pure read-back: skip straight to capture.
              if (bus.cmd_count != '0) begin
                cnt_d   = bus.cmd_count;
                state_d = S_EXEC;
              end else begin
                cnt_d   = '0;
                state_d = S_SETTLE;
              end
            end
            OP_LOAD, OP_CLEAR: begin
              cnt_d   = CW'(1);
              state_d = S_EXEC;
            end
            default: begin
              cnt_d   = '0;
              state_d = S_SETTLE;
            end
          endcase
        end
      end

      S_EXEC: begin
        sel_c = op_q;
        if (op_q == OP_LOAD) begin
          par_c = data_q;
        end
        cnt_d = cnt_q - CW'(1);
        // <=1 rather than ==1 so a corrupted zero counter cannot run away.
        if (cnt_q <= CW'(1)) begin
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        rsp_data_d  = bus.reg_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.sel       = sel_c;
  assign bus.par_out   = par_c;
  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_op_sequencer.sv
// tb/tb_shift_op_sequencer.sv - directed and random command bench with a shift register model
module tb_shift_op_sequencer;
  localparam int W  = 10;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_op_sequencer_if #(.W(W), .CW(CW)) bus ();

  shift_op_sequencer #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Downstream register driven by the DUT's sel/par_out.
  logic [W-1:0] reg_m = '0;
  always @(posedge clk) begin
    case (bus.sel)
      3'b001:  reg_m <= reg_m >> 1;
      3'b010:  reg_m <= reg_m << 1;
      3'b011:  reg_m <= {reg_m[0], reg_m[W-1:1]};
      3'b100:  reg_m <= {reg_m[W-2:0], reg_m[W-1]};
      3'b101:  reg_m <= bus.par_out;
      3'b110:  reg_m <= '0;
      default: reg_m <= reg_m;
    endcase
  end
  assign bus.reg_q = reg_m;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_reg = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [CW-1:0] cnt,
                                              input logic [W-1:0] data, input logic [W-1:0] cur);
    logic [2*W-1:0] dbl;
    int r;
    dbl = {cur, cur};
    r   = int'(cnt) % W;
    case (op)
      3'd1: return cur >> cnt;
      3'd2: return cur << cnt;
      3'd3: begin dbl = dbl >> r; return dbl[W-1:0]; end
      3'd4: begin dbl = dbl << r; return dbl[2*W-1:W]; end
      3'd5: return data;
      3'd6: return '0;
      default: return cur;
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] op, input logic [CW-1:0] cnt);
    if (op >= 3'd1 && op <= 3'd4) return int'(cnt);
    if (op == 3'd5 || op == 3'd6) return 1;
    return 0;
  endfunction

  task automatic do_cmd(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] data,
                        input int hold, input bit chain);
    int waited, cycles, selc;
    logic [W-1:0] want;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    bus.cmd_data  = data;
    want = ref_result(op, cnt, data, exp_reg);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cycles = 0;
    selc   = 0;
    while (bus.rsp_valid !== 1'b1 && cycles < 40) begin
      if (bus.sel !== 3'b000) begin
        selc++;
        chk("sel_op", bus.sel, op);
        chk("par_out_exec", bus.par_out, (op == 3'd5) ? data : '0);
      end else begin
        chk("par_out_idle", bus.par_out, 0);
      end
      chk("busy_exec", bus.busy, 1);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; cycles++;
    end
    bus.rsp_ready = 1'b0;
    chk("latency", cycles, (exp_cycles(op, cnt) == 0) ? 1 : exp_cycles(op, cnt) + 1);
    chk("sel_cycles", selc, exp_cycles(op, cnt));
    chk("rsp_data", bus.rsp_data, want);
    chk("cmd_ready_resp", bus.cmd_ready, 0);
    exp_reg = want;
    for (int i = 0; i < hold; i++) begin
      if (chain) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_count = '0;
        bus.cmd_data  = '0;
      end
      @(posedge clk); #1;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, want);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("hs_valid_clr", bus.rsp_valid, 0);
    chk("hs_cmd_ready", bus.cmd_ready, 1);
    chk("hs_busy", bus.busy, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_count = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    #2;
    chk("rst_sel", bus.sel, 0);
    chk("rst_par", bus.par_out, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_cmd(3'd5, 4'd0, 10'h2A5, 0, 1'b0);
    do_cmd(3'd5, 4'd0, 10'h001, 0, 1'b0);
    do_cmd(3'd2, 4'd3, 10'h000, 0, 1'b0);
    do_cmd(3'd1, 4'd0, 10'h3FF, 0, 1'b0);
    do_cmd(3'd0, 4'd5, 10'h155, 0, 1'b0);
    do_cmd(3'd7, 4'd3, 10'h0AA, 0, 1'b0);
    do_cmd(3'd5, 4'd0, 10'h001, 0, 1'b0);
    do_cmd(3'd4, 4'd15, 10'h000, 5, 1'b1);
    do_cmd(3'd0, 4'd0, 10'h000, 0, 1'b0);

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd1;
    bus.cmd_count = 4'd10;
    bus.cmd_data  = '0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_sel_exec", bus.sel, 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_sel", bus.sel, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    exp_reg = exp_reg >> 4;
    @(posedge clk); #1;
    chk("abort_reg", reg_m, exp_reg);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_rsp", bus.rsp_valid, 0);
    do_cmd(3'd6, 4'd7, 10'h3FF, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      do_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 10'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_op_sequencer.md
Name: shift_op_sequencer

Overview:
- Command-driven controller sitting directly upstream of the m-bit multi-operational shift register.
- Accepts one operation command per handshake and drives the register's `sel` code and parallel-load data for the required number of clock cycles.
- After the operation, captures the register's parallel outputs and returns them as a response with a valid/ready handshake.
- Turns a free-running `sel` bus into transaction-level operations with exact shift counts.

Parameters:
- W, 10: register width; matches total op/inp bit count of the downstream register.
- CW, 4: width of shift-count field; max shifts per command = 2^CW-1.

Ports:
- clk  input  1  rising-edge clock, shared with downstream register
- rst  input  1  asynchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept command
- cmd_op  input  3  operation code (encoding below)
- cmd_count  input  CW  number of shift/rotate cycles
- cmd_data  input  W  parallel-load value
- sel  output  3  operation select to downstream register
- par_out  output  W  parallel data to register inputs (bit 0 = inp1)
- reg_q  input  W  register parallel outputs (bit 0 = op1)
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  W  captured register contents
- busy  output  1  high in any state other than IDLE

Behaviour:
- sel encoding (fixed):
  - 000 hold
  - 001 shift right
  - 010 shift left
  - 011 rotate right
  - 100 rotate left
  - 101 parallel load
  - 110 clear
  - 111 hold (reserved)
- States: IDLE, EXEC, SETTLE, RESP.
- Reset (async, immediate) values:
  - state=IDLE, sel=000, par_out=0, rsp_valid=0, rsp_data=0, cmd_ready=1, busy=0
  - counter=0, latched op=000
- Reset asserted mid-operation aborts the command: no response is produced and sel returns to hold within the same cycle.
- IDLE:
  - cmd_ready=1, sel=000.
  - On cmd_valid&cmd_ready, latch op/count/data.
  - Next state by op:
    - 001-100 with count>0: EXEC, counter=count.
    - 101 or 110: EXEC, counter=1 (count ignored).
    - 000, 111, or shift/rotate with count=0: SETTLE directly; no register cycles issued.
- EXEC:
  - sel=latched op; par_out=latched data while op=101, else 0.
  - Counter decrements each cycle; on the cycle counter==1, next state is SETTLE.
  - Exactly N register cycles for N = count.
- SETTLE:
  - sel=000 for one cycle so reg_q reflects the final register edge.
  - At end of cycle, rsp_data<=reg_q, rsp_valid<=1, go to RESP.
- RESP:
  - sel=000; rsp_data stable while rsp_valid=1.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- cmd_ready is 0 in EXEC/SETTLE/RESP; cmd_valid there is not consumed and must be held by the source.
- No command pipelining: the next command is accepted no earlier than the cycle after the response handshake.
- Latency for a shift/rotate of N: accept edge, N EXEC cycles, 1 SETTLE cycle; rsp_valid rises N+1 cycles after the accept edge.
- Load/clear: rsp_valid 2 cycles after accept.
- Hold or count=0: rsp_valid 1 cycle after accept.
- Counter is CW bits with no wrap: a maximum count of 2^CW-1 issues exactly that many cycles.

Test Plan:
- Load: rst pulse, then cmd op=101 data=10'h2A5 -> sel=101 for exactly one cycle with par_out=10'h2A5; rsp_valid 2 cycles after accept; rsp_data=10'h2A5 with a behavioural register model.
- Shift: after load 10'h001, cmd op=010 count=3 -> sel=010 for exactly 3 consecutive cycles then 000; rsp_data=10'h008; rsp_valid 4 cycles after accept.
- Zero count and hold: cmd op=001 count=0 -> sel never leaves 000; rsp_valid 1 cycle later; rsp_data equals prior contents. Repeat with op=000 and op=111 -> same response.
- Max count and backpressure: load 10'h001, cmd op=100 count=15 -> 15 rotate cycles; rsp_data=10'h020. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0; new command accepted only the cycle after rsp_ready=1.
- Reset mid-EXEC: cmd op=001 count=10, assert rst after 4 EXEC cycles -> sel=000 and state IDLE immediately, no rsp_valid; after release a new clear command (op=110) yields rsp_data=0.
